// File: rtl/snn_pkg.sv
// Shared definitions for the Layer-1 -> Layer-2 spike path: default
// array geometry and the transmitter state encoding.
package snn_pkg;

   localparam int N_NEURONS_DEF = 16;
   localparam int ADDR_W_DEF    = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      EOT  = 2'd2
   } tx_state_t;

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder. Returns the index of the lowest set
// bit of vec_i and flags an all-zero input on none_o. Purely combinational.
module lsb_prio_enc #(
   parameter int N_NEURONS = 16,
   parameter int ADDR_W    = 4
) (
   input  logic [N_NEURONS-1:0] vec_i,
   output logic [ADDR_W-1:0]    idx_o,
   output logic                 none_o
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx_o  = '0;
      none_o = 1'b1;
      for (int i = N_NEURONS - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o  = ADDR_W'(i);
            none_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/spike_tx.sv
// Spike event transmitter. Captures one spike vector per timestep and
// serialises it into per-neuron events (lowest index first), followed by
// one leak-only token that closes the step.
// Optional feature: define SPIKE_TX_COUNT_EN to add the spk_count output,
// which reports the number of spike events of the last completed step.
module spike_tx
   import snn_pkg::*;
#(
   parameter int N_NEURONS = N_NEURONS_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_NEURONS-1:0] spk_vec,
   input  logic                 vec_valid,
   output logic                 vec_ready,
   output logic                 ev_valid,
   input  logic                 ev_ready,
   output logic [ADDR_W-1:0]    ev_addr,
   output logic                 ev_last,
   output logic                 spk,
   output logic                 pul
`ifdef SPIKE_TX_COUNT_EN
   ,
   output logic [ADDR_W:0]      spk_count
`endif
);

   tx_state_t              state_q, state_d;
   logic [N_NEURONS-1:0]   pend_q, pend_d;
   logic                   vec_ready_q, vec_ready_d;
   logic                   ev_valid_q, ev_valid_d;
   logic                   spk_q, spk_d;
   logic                   last_q, last_d;
   logic [ADDR_W-1:0]      enc_idx;
   logic                   enc_none;

   lsb_prio_enc #(
      .N_NEURONS (N_NEURONS),
      .ADDR_W    (ADDR_W)
   ) u_enc (
      .vec_i  (pend_q),
      .idx_o  (enc_idx),
      .none_o (enc_none)
   );

   // Next-state logic; output flags are derived from the next state so they
   // can be registered alongside it. Bits are cleared lowest-first by the
   // x & (x-1) idiom, which matches the encoder's choice of index.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      case (state_q)
         IDLE: begin
            if (vec_valid) begin
               pend_d  = spk_vec;
               state_d = (spk_vec == '0) ? EOT : EMIT;
            end
         end
         EMIT: begin
            if (ev_ready) begin
               pend_d  = pend_q & (pend_q - N_NEURONS'(1));
               state_d = (pend_d == '0) ? EOT : EMIT;
            end
         end
         EOT: begin
            if (ev_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            pend_d  = '0;
         end
      endcase
      vec_ready_d = (state_d == IDLE);
      ev_valid_d  = (state_d != IDLE);
      spk_d       = (state_d == EMIT);
      last_d      = (state_d == EOT);
   end

   // FSM state, pending vector and registered output flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         vec_ready_q <= 1'b1;
         ev_valid_q  <= 1'b0;
         spk_q       <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         vec_ready_q <= vec_ready_d;
         ev_valid_q  <= ev_valid_d;
         spk_q       <= spk_d;
         last_q      <= last_d;
      end
   end

   assign vec_ready = vec_ready_q;
   assign ev_valid  = ev_valid_q;
   assign spk       = spk_q;
   assign ev_last   = last_q;
   // Address is only meaningful on spike events; the leak token carries 0.
   assign ev_addr   = (spk_q && !enc_none) ? enc_idx : '0;
   // Strobe is deliberately unregistered so it coincides with the handshake.
   assign pul       = ev_valid_q && ev_ready;

`ifdef SPIKE_TX_COUNT_EN
   logic [ADDR_W:0] cnt_q;
   logic [ADDR_W:0] count_q;

   // Per-step spike counter; published on the token handshake and held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         count_q <= '0;
      end else begin
         if (state_q == IDLE && vec_valid) begin
            cnt_q <= '0;
         end else if (state_q == EMIT && ev_ready) begin
            cnt_q <= cnt_q + (ADDR_W+1)'(1);
         end
         if (state_q == EOT && ev_ready) begin
            count_q <= cnt_q;
         end
      end
   end

   assign spk_count = count_q;
`endif

endmodule

// File: tb/tb_spike_tx.sv
// Bench for spike_tx: queue-based event model with a per-cycle compare
// process, plus directed scenarios with literal expectations.
module tb_spike_tx;

   localparam int N  = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  spk_vec = '0;
   logic          vec_valid = 1'b0;
   logic          vec_ready;
   logic          ev_valid;
   logic          ev_ready = 1'b0;
   logic [AW-1:0] ev_addr;
   logic          ev_last;
   logic          spk;
   logic          pul;
`ifdef SPIKE_TX_COUNT_EN
   logic [AW:0]   spk_count;
`endif

   spike_tx #(.N_NEURONS(N), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .spk_vec   (spk_vec),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_addr   (ev_addr),
      .ev_last   (ev_last),
      .spk       (spk),
      .pul       (pul)
`ifdef SPIKE_TX_COUNT_EN
      ,
      .spk_count (spk_count)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int addr; int spk; int last; int cnt;} item_t;
   typedef struct {int addr; int spk; int last; int cyc;} hs_t;

   item_t q[$];
   hs_t   log[$];
   int    model_cnt = 0;
   int    nspk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: every accepted vector expands into its set-bit indices in
   // ascending order plus one token; outputs are checked against the head.
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_vec_ready", int'(vec_ready), 1);
         chk("rst_ev_valid", int'(ev_valid), 0);
         chk("rst_ev_addr", int'(ev_addr), 0);
         chk("rst_ev_last", int'(ev_last), 0);
         chk("rst_spk", int'(spk), 0);
         chk("rst_pul", int'(pul), 0);
`ifdef SPIKE_TX_COUNT_EN
         chk("rst_spk_count", int'(spk_count), 0);
`endif
         q.delete();
         model_cnt = 0;
      end else begin
         chk("vec_ready", int'(vec_ready), int'(q.size() == 0));
         chk("ev_valid", int'(ev_valid), int'(q.size() != 0));
         chk("pul", int'(pul), int'(ev_valid && ev_ready));
         if (q.size() != 0) begin
            chk("ev_addr", int'(ev_addr), q[0].addr);
            chk("spk", int'(spk), q[0].spk);
            chk("ev_last", int'(ev_last), q[0].last);
         end
`ifdef SPIKE_TX_COUNT_EN
         chk("spk_count", int'(spk_count), model_cnt);
`endif
         if (ev_valid && ev_ready) begin
            log.push_back('{int'(ev_addr), int'(spk), int'(ev_last), cyc});
            if (q.size() != 0) begin
               if (q[0].last != 0) model_cnt = q[0].cnt;
               void'(q.pop_front());
            end
         end
         if (vec_valid && vec_ready) begin
            nspk = 0;
            for (int i = 0; i < N; i++) begin
               if (spk_vec[i]) begin
                  q.push_back('{i, 1, 0, 0});
                  nspk++;
               end
            end
            q.push_back('{0, 0, 1, nspk});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a vector and wait for it to be accepted; acc is the accept cycle.
   task automatic send(input logic [N-1:0] v, input bit hold, output int acc);
      int n;
      n = 0;
      spk_vec   = v;
      vec_valid = 1'b1;
      while (!vec_ready && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) chk("send_timeout", 0, 1);
      acc = cyc;
      step();
      if (!hold) vec_valid = 1'b0;
   endtask

   task automatic wait_log(input int n);
      int b;
      b = 0;
      while (log.size() < n && b < 3000) begin
         step();
         b++;
      end
      if (log.size() < n) chk("drain_timeout", log.size(), n);
   endtask

   initial begin
      int acc, acc2, sz;
      int ea[5];

      ev_ready = 1'b1;
      rst = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();

      // All-zero vector: a single leak token.
      log.delete();
      send(16'h0000, 1'b0, acc);
      chk("zero_vec_ready_busy", int'(vec_ready), 0);
      step();
      chk("zero_vec_ready_back", int'(vec_ready), 1);
      chk("zero_items", log.size(), 1);
      if (log.size() >= 1) begin
         chk("zero_tok_last", log[0].last, 1);
         chk("zero_tok_spk", log[0].spk, 0);
         chk("zero_tok_addr", log[0].addr, 0);
         chk("zero_tok_cycle", log[0].cyc, acc + 1);
      end

      // 16'h8421 with ev_ready tied high: 0,5,10,15, token back-to-back.
      log.delete();
      send(16'h8421, 1'b0, acc);
      wait_log(5);
      repeat (2) step();
      chk("p8421_items", log.size(), 5);
      ea = '{0, 5, 10, 15, 0};
      if (log.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            chk("p8421_addr", log[i].addr, ea[i]);
            chk("p8421_spk", log[i].spk, (i < 4) ? 1 : 0);
            chk("p8421_last", log[i].last, (i == 4) ? 1 : 0);
         end
         chk("p8421_first_cycle", log[0].cyc, acc + 1);
         chk("p8421_consecutive", log[4].cyc - log[0].cyc, 4);
      end
`ifdef SPIKE_TX_COUNT_EN
      chk("p8421_spk_count", int'(spk_count), 4);
`endif

      // 16'hFFFF with random backpressure.
      log.delete();
      ev_ready = 1'b0;
      send(16'hFFFF, 1'b0, acc);
      for (int b = 0; b < 3000 && log.size() < 17; b++) begin
         ev_ready = 1'($urandom_range(0, 1));
         step();
      end
      ev_ready = 1'b1;
      repeat (2) step();
      chk("ffff_items", log.size(), 17);
      if (log.size() == 17) begin
         for (int i = 0; i < 16; i++) chk("ffff_addr", log[i].addr, i);
         chk("ffff_tok_last", log[16].last, 1);
         chk("ffff_tok_spk", log[16].spk, 0);
      end
`ifdef SPIKE_TX_COUNT_EN
      chk("ffff_spk_count", int'(spk_count), 16);
`endif

      // Second vector held valid during EMIT.
      log.delete();
      send(16'h0003, 1'b1, acc);
      send(16'h0100, 1'b0, acc2);
      wait_log(5);
      repeat (2) step();
      chk("hold_items", log.size(), 5);
      ea = '{0, 1, 0, 8, 0};
      if (log.size() == 5) begin
         for (int i = 0; i < 5; i++) chk("hold_addr", log[i].addr, ea[i]);
         chk("hold_tok_a", log[2].last, 1);
         chk("hold_accept_b", acc2, log[2].cyc + 1);
         chk("hold_first_b", log[3].cyc, log[2].cyc + 2);
      end

      // Reset mid-step while address 5 of 16'h00F0 is presented.
      log.delete();
      ev_ready = 1'b0;
      send(16'h00F0, 1'b0, acc);
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
      @(negedge clk);
      chk("mid_addr5", int'(ev_addr), 5);
      #1;
      rst = 1'b0;
      #1;
      chk("mid_rst_ev_valid", int'(ev_valid), 0);
      chk("mid_rst_vec_ready", int'(vec_ready), 1);
      sz = log.size();
      chk("mid_pre_items", sz, 1);
      ev_ready = 1'b1;
      repeat (3) step();
      chk("mid_no_more_pul", log.size(), sz);
      rst = 1'b1;
      step();
      send(16'h0001, 1'b0, acc);
      wait_log(sz + 2);
      repeat (2) step();
      chk("post_items", log.size(), sz + 2);
      if (log.size() == sz + 2) begin
         chk("post_addr", log[sz].addr, 0);
         chk("post_spk", log[sz].spk, 1);
         chk("post_tok_last", log[sz+1].last, 1);
      end
`ifdef SPIKE_TX_COUNT_EN
      chk("post_spk_count", int'(spk_count), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1);
   end

endmodule
